// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII frame parser: character codes,
// character classes, parser states and error codes.
package ascii_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SLASH = 8'h2F;
  localparam logic [7:0] ASC_SEMI  = 8'h3B;
  localparam logic [7:0] ASC_AT    = 8'h40;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_DIGIT,
    CLS_PAD,
    CLS_START,
    CLS_MINUS,
    CLS_SEP,
    CLS_SNR_END,
    CLS_CTL_END
  } char_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DISCARD
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_COUNT    = 2'd3;

endpackage

// File: rtl/ascii_classify.sv
// Combinational byte classifier: maps a received ASCII byte to its
// character class and, for digits, the decimal value.
module ascii_classify
  import ascii_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [2:0] cls_o,
  output logic [3:0] digit_o
);

  char_class_t cls;

  // Decode the byte into class and digit value
  always_comb begin
    cls     = CLS_ILLEGAL;
    digit_o = '0;
    if (data_i >= ASC_0 && data_i <= ASC_9) begin
      cls     = CLS_DIGIT;
      digit_o = data_i[3:0];
    end else begin
      case (data_i)
        ASC_SPACE: cls = CLS_PAD;
        ASC_PLUS:  cls = CLS_START;
        ASC_MINUS: cls = CLS_MINUS;
        ASC_SLASH: cls = CLS_SEP;
        ASC_SEMI:  cls = CLS_SNR_END;
        ASC_AT:    cls = CLS_CTL_END;
        default:   cls = CLS_ILLEGAL;
      endcase
    end
  end

  assign cls_o = cls;

endmodule

// File: rtl/ascii_frame_parser.sv
// ASCII frame parser: decodes '+'-started frames into either a signed SNR
// value (';' terminated) or NUM_CH unsigned control fields ('@' terminated).
// Results and errors are reported one cycle after the terminating byte.
module ascii_frame_parser
  import ascii_pkg::*;
#(
  parameter int DOUT_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int MAX_DIGITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     snr_valid,
  output logic [DOUT_W-1:0]        snr_value,
  output logic                     gpio_valid,
  output logic [NUM_CH*DOUT_W-1:0] gpio_data,
  output logic                     frame_err,
  output logic [1:0]               err_code
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_DIGITS);
  localparam logic [DOUT_W-1:0] SNR_POS_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] SNR_NEG_MAX = {1'b1, {(DOUT_W-1){1'b0}}};

  logic [2:0]  cls_raw;
  logic [3:0]  digit;
  char_class_t cls;

  ascii_classify u_classify (
    .data_i  (rx_data),
    .cls_o   (cls_raw),
    .digit_o (digit)
  );

  assign cls = char_class_t'(cls_raw);

  state_t                    state_q, state_d;
  logic [DOUT_W-1:0]         acc_q, acc_d;
  logic                      neg_q, neg_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_CH*DOUT_W-1:0]  fields_q, fields_d;
  logic                      snr_valid_q, snr_valid_d;
  logic [DOUT_W-1:0]         snr_value_q, snr_value_d;
  logic                      gpio_valid_q, gpio_valid_d;
  logic [NUM_CH*DOUT_W-1:0]  gpio_data_q, gpio_data_d;
  logic                      frame_err_q, frame_err_d;
  logic [1:0]                err_code_q, err_code_d;
  logic [1:0]                err;
  logic [DOUT_W+3:0]         prod;

  // acc*10 + digit, widened by 4 bits so any carry out signals overflow
  assign prod = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{DOUT_W{1'b0}}, digit};

  // Next-state logic: frame sequencing, accumulation and commit/error decisions
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    fields_d     = fields_q;
    snr_valid_d  = 1'b0;
    snr_value_d  = snr_value_q;
    gpio_valid_d = 1'b0;
    gpio_data_d  = gpio_data_q;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    err          = ERR_NONE;

    if (rx_valid) begin
      if (cls == CLS_START) begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        neg_d   = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end else if (state_q == ST_ACCUM) begin
        case (cls)
          CLS_DIGIT: begin
            if (cnt_q == CNT_MAX || prod[DOUT_W+3:DOUT_W] != 4'd0) begin
              err = ERR_OVERFLOW;
            end else begin
              acc_d = prod[DOUT_W-1:0];
              cnt_d = cnt_q + 1'b1;
            end
          end
          CLS_PAD: ;
          CLS_MINUS: begin
            if (idx_q == '0 && cnt_q == '0) neg_d = 1'b1;
            else                            err   = ERR_ILLEGAL;
          end
          CLS_SEP: begin
            if (idx_q == LAST_IDX) begin
              err = ERR_COUNT;
            end else begin
              for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (idx_q == IDX_W'(k)) fields_d[k*DOUT_W +: DOUT_W] = acc_q;
              end
              acc_d = '0;
              neg_d = 1'b0;
              cnt_d = '0;
              idx_d = idx_q + 1'b1;
            end
          end
          CLS_SNR_END: begin
            if (idx_q != '0) begin
              err = ERR_COUNT;
            end else if (neg_q ? (acc_q > SNR_NEG_MAX) : (acc_q > SNR_POS_MAX)) begin
              err = ERR_OVERFLOW;
            end else begin
              snr_value_d = neg_q ? -acc_q : acc_q;
              snr_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
          CLS_CTL_END: begin
            if (idx_q != LAST_IDX) begin
              err = ERR_COUNT;
            end else if (neg_q) begin
              err = ERR_ILLEGAL;
            end else begin
              for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (idx_q == IDX_W'(k)) fields_d[k*DOUT_W +: DOUT_W] = acc_q;
              end
              // All fields are presented together from the staging register
              gpio_data_d  = fields_d;
              gpio_valid_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
          default: err = ERR_ILLEGAL;
        endcase

        if (err != ERR_NONE) begin
          frame_err_d = 1'b1;
          err_code_d  = err;
          state_d     = ST_DISCARD;
        end
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      fields_q     <= '0;
      snr_valid_q  <= 1'b0;
      snr_value_q  <= '0;
      gpio_valid_q <= 1'b0;
      gpio_data_q  <= '0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      fields_q     <= fields_d;
      snr_valid_q  <= snr_valid_d;
      snr_value_q  <= snr_value_d;
      gpio_valid_q <= gpio_valid_d;
      gpio_data_q  <= gpio_data_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign snr_valid  = snr_valid_q;
  assign snr_value  = snr_value_q;
  assign gpio_valid = gpio_valid_q;
  assign gpio_data  = gpio_data_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ascii_frame_parser.sv
// Directed bench for ascii_frame_parser: a 4-channel instance and a
// 1-channel instance, each with its own expected-event queue.
module tb_ascii_frame_parser;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rv0 = 1'b0, rv1 = 1'b0;
  logic [7:0]   rd0 = 8'h00, rd1 = 8'h00;

  logic         snr_valid0, gpio_valid0, frame_err0;
  logic [31:0]  snr_value0;
  logic [127:0] gpio_data0;
  logic [1:0]   err_code0;

  logic         snr_valid1, gpio_valid1, frame_err1;
  logic [31:0]  snr_value1;
  logic [31:0]  gpio_data1;
  logic [1:0]   err_code1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int           kind;   // 1 snr, 2 gpio, 3 error
    logic [31:0]  snr;
    logic [127:0] gpio;
    logic [1:0]   code;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0]  m_snr  [2];
  logic [127:0] m_gpio [2];
  logic [1:0]   m_code [2];

  ascii_frame_parser #(.DOUT_W(32), .NUM_CH(4), .MAX_DIGITS(10)) dut0 (
    .clk(clk), .reset(reset), .rx_valid(rv0), .rx_data(rd0),
    .snr_valid(snr_valid0), .snr_value(snr_value0),
    .gpio_valid(gpio_valid0), .gpio_data(gpio_data0),
    .frame_err(frame_err0), .err_code(err_code0)
  );

  ascii_frame_parser #(.DOUT_W(32), .NUM_CH(1), .MAX_DIGITS(10)) dut1 (
    .clk(clk), .reset(reset), .rx_valid(rv1), .rx_data(rd1),
    .snr_valid(snr_valid1), .snr_value(snr_value1),
    .gpio_valid(gpio_valid1), .gpio_data(gpio_data1),
    .frame_err(frame_err1), .err_code(err_code1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d, input logic sv, input logic gv, input logic fe,
                     input logic [31:0] snr, input logic [127:0] gp, input logic [1:0] ec);
    int   k;
    exp_t e;
    k = fe ? 3 : (gv ? 2 : (sv ? 1 : 0));
    if (k == 0) return;
    chk($sformatf("d%0d_exclusive", d), 128'($countones({sv, gv, fe})), 128'd1);
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk($sformatf("d%0d_unexpected_event_kind", d), 128'(k), 128'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("d%0d_kind", d),    128'(k),     128'(e.kind));
    chk($sformatf("d%0d_latency", d), 128'(cyc),   128'(e.cyc));
    chk($sformatf("d%0d_snr", d),     128'(snr),   128'(e.snr));
    chk($sformatf("d%0d_gpio", d),    gp,          e.gpio);
    chk($sformatf("d%0d_errcode", d), 128'(ec),    128'(e.code));
  endtask

  always @(negedge clk) begin
    mon(0, snr_valid0, gpio_valid0, frame_err0, snr_value0, gpio_data0, err_code0);
    mon(1, snr_valid1, gpio_valid1, frame_err1, snr_value1, {96'b0, gpio_data1}, err_code1);
  end

  task automatic send_byte(input int d, input byte b);
    if (d == 0) begin rv0 = 1'b1; rd0 = b; end
    else        begin rv1 = 1'b1; rd1 = b; end
    @(posedge clk); #1;
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends s; when kind != 0, the last byte is the terminator and an event
  // carrying the updated model snapshot is expected one cycle later.
  task automatic send_frame(input int d, input string s, input int kind, input logic [127:0] val);
    exp_t e;
    for (int i = 0; i < s.len() - 1; i++) send_byte(d, s[i]);
    if (kind != 0) begin
      case (kind)
        1: m_snr[d]  = val[31:0];
        2: m_gpio[d] = val;
        default: m_code[d] = val[1:0];
      endcase
      e.kind = kind;
      e.snr  = m_snr[d];
      e.gpio = m_gpio[d];
      e.code = m_code[d];
      e.cyc  = cyc + 1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    send_byte(d, s[s.len()-1]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv0   = 1'b0;
    rv1   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_snr[d]  = '0;
      m_gpio[d] = '0;
      m_code[d] = '0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_snr0"},    128'(snr_value0), 128'd0);
    chk({tag, "_gpio0"},   gpio_data0,       128'd0);
    chk({tag, "_code0"},   128'(err_code0),  128'd0);
    chk({tag, "_pulses0"}, 128'({snr_valid0, gpio_valid0, frame_err0}), 128'd0);
    chk({tag, "_snr1"},    128'(snr_value1), 128'd0);
    chk({tag, "_gpio1"},   128'(gpio_data1), 128'd0);
  endtask

  initial begin
    do_reset();
    chk_reset_state("reset");

    // Main function on the 4-channel instance
    send_frame(0, "+ 99;", 1, 128'd99);
    send_frame(0, "+-99;", 1, 128'h0000_0000_0000_0000_0000_0000_FFFF_FF9D);
    send_frame(0, "+1/22/ 333/4096@", 2, {32'd4096, 32'd333, 32'd22, 32'd1});
    send_frame(0, "+1/2@", 3, 128'd3);
    send_frame(0, "+5;", 1, 128'd5);
    send_frame(0, "+12x", 3, 128'd1);
    send_frame(0, "3;", 0, 128'd0);
    send_frame(0, "+1/2/3/4/", 3, 128'd3);
    send_frame(0, "5@", 0, 128'd0);
    send_frame(0, "+ /  / /@", 2, 128'd0);
    send_frame(0, "+3", 0, 128'd0);
    idle(3);
    send_frame(0, "4;", 1, 128'd34);
    send_frame(0, "+1/+7;", 1, 128'd7);
    send_frame(0, "+2147483648;", 3, 128'd2);
    send_frame(0, "+-2147483648;", 1, 128'h8000_0000);
    send_frame(0, "+00000000001", 3, 128'd2);
    send_frame(0, ";", 0, 128'd0);
    send_frame(0, "+0000000009;", 1, 128'd9);
    send_frame(0, "+1-", 3, 128'd1);
    send_frame(0, "2;", 0, 128'd0);
    send_frame(0, "+5@", 3, 128'd3);
    send_frame(0, "abc;@-/9 ", 0, 128'd0);
    send_frame(0, "+2147483647;", 1, 128'h7FFF_FFFF);

    // Single-channel instance
    send_frame(1, "+4294967296", 3, 128'd2);
    send_frame(1, "@", 0, 128'd0);
    send_frame(1, "+4294967295@", 2, 128'hFFFF_FFFF);
    send_frame(1, "+1/", 3, 128'd3);
    send_frame(1, "+-5@", 3, 128'd1);
    send_frame(1, "+12x", 3, 128'd1);
    send_frame(1, "+ @", 2, 128'd0);

    // Reset in the middle of a frame drops it silently
    send_frame(0, "+12", 0, 128'd0);
    do_reset();
    chk_reset_state("midreset");
    send_frame(0, "3;", 0, 128'd0);
    send_frame(0, "+7;", 1, 128'd7);

    idle(4);
    chk("q0_drained", 128'(q0.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
